// File: rtl/emu_step_transactor.sv
// Byte-serial co-emulation transactor: host-loaded stimulus shadow, counted DUT bursts, auto-capture.
// Optional macro EMU_BREAK_EN adds dut_brk/brk_hit for an early break-stop of a run.
module emu_step_transactor #(
   parameter int N_STIM = 5,
   parameter int N_OUT  = 5,
   parameter int AW     = 3,
   parameter int CNT_W  = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [7:0]           host_din,
   input  logic [AW-1:0]        host_addr,
   input  logic                 host_wr,
   input  logic                 host_load,
   input  logic                 host_get,
   input  logic                 host_run,
   input  logic [CNT_W-1:0]     host_cnt,
   output logic [7:0]           host_dout,
   output logic                 busy,
   output logic                 done,
   output logic [8*N_STIM-1:0]  stim_vec,
   input  logic [8*N_OUT-1:0]   out_vec,
   output logic                 dut_ce
`ifdef EMU_BREAK_EN
   ,
   input  logic                 dut_brk,
   output logic                 brk_hit
`endif
);

   typedef enum logic [1:0] {IDLE, RUN, CAPTURE} state_t;

   state_t           state;
   logic [CNT_W-1:0] count;
   logic [7:0]       shadow  [N_STIM];
   logic [7:0]       out_reg [N_OUT];
   logic [7:0]       rd_byte;
   logic             brk_now;

`ifdef EMU_BREAK_EN
   assign brk_now = dut_brk & dut_ce;
`else
   assign brk_now = 1'b0;
`endif

   // Unmapped read addresses return zero.
   always_comb begin
      rd_byte = 8'h00;
      for (int i = 0; i < N_OUT; i++) begin
         if (host_addr == AW'(i)) rd_byte = out_reg[i];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         count     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         dut_ce    <= 1'b0;
         stim_vec  <= '0;
         host_dout <= 8'h00;
         for (int i = 0; i < N_STIM; i++) shadow[i] <= 8'h00;
         for (int i = 0; i < N_OUT; i++) out_reg[i] <= 8'h00;
`ifdef EMU_BREAK_EN
         brk_hit   <= 1'b0;
`endif
      end else begin
         done      <= 1'b0;
         host_dout <= rd_byte;

         // Shadow writes are accepted in every state; out-of-range addresses match nothing.
         for (int i = 0; i < N_STIM; i++) begin
            if (host_wr && host_addr == AW'(i)) shadow[i] <= host_din;
         end

         case (state)
            IDLE: begin
               if (host_load) begin
                  for (int i = 0; i < N_STIM; i++) stim_vec[8*i +: 8] <= shadow[i];
               end
               if (host_run) begin
                  count <= host_cnt;
                  busy  <= 1'b1;
`ifdef EMU_BREAK_EN
                  brk_hit <= 1'b0;
`endif
                  if (host_cnt != '0) begin
                     state  <= RUN;
                     dut_ce <= 1'b1;
                  end else begin
                     state  <= CAPTURE;
                  end
               end else if (host_get) begin
                  for (int i = 0; i < N_OUT; i++) out_reg[i] <= out_vec[8*i +: 8];
               end
            end

            RUN: begin
               if (count != '0) count <= count - CNT_W'(1);
               // count==1 marks the last enabled cycle of the burst.
               if (count <= CNT_W'(1) || brk_now) begin
                  state  <= CAPTURE;
                  dut_ce <= 1'b0;
`ifdef EMU_BREAK_EN
                  if (brk_now) brk_hit <= 1'b1;
`endif
               end
            end

            CAPTURE: begin
               for (int i = 0; i < N_OUT; i++) out_reg[i] <= out_vec[8*i +: 8];
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= IDLE;
            end

            default: begin
               state  <= IDLE;
               busy   <= 1'b0;
               dut_ce <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_emu_step_transactor.sv
// Self-checking bench for emu_step_transactor with a counting DUT model and a spec-level reference model.
module tb_emu_step_transactor;

   localparam int N_STIM = 5;
   localparam int N_OUT  = 5;
   localparam int AW     = 3;
   localparam int CNT_W  = 16;

   logic                 clk = 1'b0;
   logic                 reset_n;
   logic [7:0]           host_din;
   logic [AW-1:0]        host_addr;
   logic                 host_wr, host_load, host_get, host_run;
   logic [CNT_W-1:0]     host_cnt;
   logic [7:0]           host_dout;
   logic                 busy, done, dut_ce;
   logic [8*N_STIM-1:0]  stim_vec;
   logic [8*N_OUT-1:0]   out_vec;
   logic                 dut_brk;
`ifdef EMU_BREAK_EN
   logic                 brk_hit;
`endif

   logic [7:0] dut_cnt;

   int checks   = 0;
   int failures = 0;

   logic [7:0] model_shadow [N_STIM];
   logic [7:0] model_stim   [N_STIM];
   logic [7:0] model_out    [N_OUT];
   logic [7:0] model_cnt;

   emu_step_transactor #(
      .N_STIM(N_STIM), .N_OUT(N_OUT), .AW(AW), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .host_din(host_din), .host_addr(host_addr), .host_wr(host_wr),
      .host_load(host_load), .host_get(host_get), .host_run(host_run),
      .host_cnt(host_cnt), .host_dout(host_dout), .busy(busy), .done(done),
      .stim_vec(stim_vec), .out_vec(out_vec), .dut_ce(dut_ce)
`ifdef EMU_BREAK_EN
      , .dut_brk(dut_brk), .brk_hit(brk_hit)
`endif
   );

   always #5 clk = ~clk;

   // Toy DUT: a counter that advances only on enabled cycles; it echoes stimulus bytes 0..3.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) dut_cnt <= 8'h00;
      else if (dut_ce) dut_cnt <= dut_cnt + 8'h01;
   end
   assign out_vec = {stim_vec[31:0], dut_cnt};

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [8*N_STIM-1:0] stim_flat();
      logic [8*N_STIM-1:0] v;
      for (int i = 0; i < N_STIM; i++) v[8*i +: 8] = model_stim[i];
      return v;
   endfunction

   task automatic model_reset;
      for (int i = 0; i < N_STIM; i++) begin model_shadow[i] = 8'h00; model_stim[i] = 8'h00; end
      for (int i = 0; i < N_OUT; i++) model_out[i] = 8'h00;
      model_cnt = 8'h00;
   endtask

   // What the toy DUT presents on out_vec given the model's view.
   task automatic model_capture;
      model_out[0] = model_cnt;
      for (int i = 1; i < N_OUT; i++) model_out[i] = model_stim[i-1];
   endtask

   task automatic wr(input int a, input logic [7:0] d);
      host_wr = 1'b1; host_addr = AW'(a); host_din = d;
      tick();
      host_wr = 1'b0;
      if (a < N_STIM) model_shadow[a] = d;
   endtask

   task automatic load;
      host_load = 1'b1;
      tick();
      host_load = 1'b0;
      for (int i = 0; i < N_STIM; i++) model_stim[i] = model_shadow[i];
      chk("load_stim", stim_vec, stim_flat());
      chk("load_ce", dut_ce, 1'b0);
   endtask

   task automatic rd_chk(input int a);
      logic [7:0] exp;
      host_addr = AW'(a);
      tick();
      exp = (a < N_OUT) ? model_out[a] : 8'h00;
      chk($sformatf("rd%0d", a), host_dout, exp);
   endtask

   // Run of n cycles; optional simultaneous load/get, a command burst at cycle inj_t, a break at brk_at.
   task automatic do_run(input int n, input bit with_load, input bit with_get,
                         input int inj_t, input int brk_at);
      int eff;
      eff = (brk_at > 0 && brk_at < n) ? brk_at : n;
      host_cnt = CNT_W'(n); host_run = 1'b1; host_load = with_load; host_get = with_get;
      if (with_load) for (int i = 0; i < N_STIM; i++) model_stim[i] = model_shadow[i];
      tick();
      host_run = 1'b0; host_load = 1'b0; host_get = 1'b0;
      for (int t = 1; t <= eff + 2; t++) begin
         chk($sformatf("busy_t%0d", t), busy, (t <= eff + 1) ? 1'b1 : 1'b0);
         chk($sformatf("ce_t%0d", t), dut_ce, (t <= eff) ? 1'b1 : 1'b0);
         chk($sformatf("done_t%0d", t), done, (t == eff + 2) ? 1'b1 : 1'b0);
         chk($sformatf("stim_t%0d", t), stim_vec, stim_flat());
`ifdef EMU_BREAK_EN
         chk($sformatf("brk_hit_t%0d", t), brk_hit, (brk_at > 0 && brk_at <= n && t > eff) ? 1'b1 : 1'b0);
`endif
         dut_brk = (t == brk_at);
         if (t == inj_t) begin
            host_load = 1'b1; host_get = 1'b1; host_run = 1'b1; host_cnt = CNT_W'(3);
            host_wr = 1'b1; host_addr = AW'(1); host_din = 8'hAA;
            model_shadow[1] = 8'hAA;
         end else begin
            host_load = 1'b0; host_get = 1'b0; host_run = 1'b0; host_wr = 1'b0;
         end
         tick();
      end
      dut_brk = 1'b0; host_load = 1'b0; host_get = 1'b0; host_run = 1'b0; host_wr = 1'b0;
      model_cnt = model_cnt + 8'(eff);
      model_capture();
      $display("run n=%0d eff=%0d load=%0d get=%0d inj=%0d brk=%0d", n, eff, with_load, with_get, inj_t, brk_at);
   endtask

   initial begin
      reset_n = 1'b1;
      host_din = 8'h00; host_addr = '0; host_wr = 1'b0; host_load = 1'b0;
      host_get = 1'b0; host_run = 1'b0; host_cnt = '0; dut_brk = 1'b0;
      model_reset();
      #1 reset_n = 1'b0;
      #1;
      chk("rst_dout", host_dout, 8'h00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_ce", dut_ce, 1'b0);
      chk("rst_stim", stim_vec, '0);
      tick();
      reset_n = 1'b1;
      tick();

      // Basic load
      wr(0, 8'h11); wr(1, 8'h22); wr(2, 8'h33); wr(3, 8'h44); wr(4, 8'h55);
      load();
      chk("load_const", stim_vec, 40'h5544332211);
      $display("load stim=%0h", stim_vec);

      // Seven-cycle burst from a fresh DUT counter
      do_run(7, 1'b0, 1'b0, 0, 0);
      rd_chk(0);
      chk("rd0_const", host_dout, 8'h07);

      // Zero-length run: capture only
      do_run(0, 1'b0, 1'b0, 0, 0);
      for (int a = 0; a < 8; a++) rd_chk(a);

      // Commands issued mid-run and in the capture cycle are ignored; writes still land
      do_run(6, 1'b0, 1'b0, 2, 0);
      do_run(4, 1'b0, 1'b0, 5, 0);
      for (int a = 0; a < 8; a++) rd_chk(a);
      load();
      chk("aa_stim", stim_vec[15:8], 8'hAA);

      // Load+run and get+run in the same cycle
      wr(3, 8'h5C);
      do_run(3, 1'b1, 1'b0, 0, 0);
      do_run(2, 1'b0, 1'b1, 0, 0);
      for (int a = 0; a < 5; a++) rd_chk(a);

      // Randomized runs with scattered shadow writes (including ignored addresses)
      for (int r = 0; r < 8; r++) begin
         int nw;
         nw = $urandom_range(0, 3);
         for (int w = 0; w < nw; w++) wr($urandom_range(0, 7), 8'($urandom));
         do_run($urandom_range(1, 20), 1'($urandom_range(0, 1)), 1'b0, 0, 0);
         for (int a = 0; a < 8; a++) rd_chk(a);
      end

      // Manual get in idle: no busy, no done
      wr(0, 8'hC3); load();
      host_get = 1'b1;
      model_capture();
      tick();
      host_get = 1'b0;
      chk("get_busy", busy, 1'b0);
      chk("get_done", done, 1'b0);
      tick();
      chk("get_done2", done, 1'b0);
      for (int a = 0; a < 8; a++) rd_chk(a);
      $display("get out0=%0h", model_out[0]);

`ifdef EMU_BREAK_EN
      do_run(100, 1'b0, 1'b0, 0, 4);
      rd_chk(0);
      do_run(3, 1'b0, 1'b0, 0, 0);
      rd_chk(0);
`endif

      // Asynchronous reset in the third cycle of a 10-cycle run
      host_cnt = CNT_W'(10); host_run = 1'b1;
      tick();
      host_run = 1'b0;
      tick(); tick();
      chk("pre_rst_ce", dut_ce, 1'b1);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_ce", dut_ce, 1'b0);
      chk("arst_busy", busy, 1'b0);
      chk("arst_stim", stim_vec, '0);
      model_reset();
      tick();
      reset_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         chk("arst_no_done", done, 1'b0);
         tick();
      end
      for (int a = 0; a < 8; a++) rd_chk(a);
      $display("reset mid-run checked");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

endmodule
